// File: rtl/exe_divider_pkg.sv
// Shared EXE-stage constants: word width, div_op encodings and divider FSM states.
// Reused by the decoder, the ID/EXE register and exe_divider.
package exe_divider_pkg;

   localparam int WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } div_state_e;

   // Bit 0 clear selects the signed flavours; bit 1 set selects the remainder.
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_rem(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/exe_divider.sv
// Iterative restoring radix-2 divider for the EXE stage (DIV/DIVU/REM/REMU).
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterations.
module exe_divider
   import exe_divider_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  div_valid,
   input  logic [1:0]            div_op,
   input  logic [WORD_WIDTH-1:0] opA,
   input  logic [WORD_WIDTH-1:0] opB,
   input  logic [4:0]            rd,
   output logic                  busy,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] result,
   output logic [4:0]            done_rd
);

   localparam int         W          = WORD_WIDTH;
   localparam logic [5:0] LAST_COUNT = 6'd32;
   localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};

   div_state_e   state_reg, state_next;
   logic [5:0]   count_reg, count_next;
   logic [1:0]   op_reg, op_next;
   logic [4:0]   rd_reg, rd_next;
   logic [W-1:0] quo_reg, quo_next;
   logic [W:0]   rem_reg, rem_next;
   logic [W-1:0] divisor_reg, divisor_next;
   logic [W-1:0] dividend_reg, dividend_next;
   logic         neg_q_reg, neg_q_next;
   logic         neg_r_reg, neg_r_next;
   logic         zero_reg, zero_next;
   logic         ovf_reg, ovf_next;
   logic [W-1:0] result_reg, result_next;
   logic [4:0]   done_rd_reg, done_rd_next;

   logic [W:0]   shifted;
   logic [W+1:0] trial;
   logic         a_neg, b_neg;
   logic [W-1:0] mag_a, mag_b;
   logic [W-1:0] quo_fix, rem_fix, final_value;
   logic         finish;

   always_comb begin
      shifted = {rem_reg[W-1:0], quo_reg[W-1]};
      trial   = {1'b0, shifted} - {2'b00, divisor_reg};
      a_neg   = op_is_signed(div_op) & opA[W-1];
      b_neg   = op_is_signed(div_op) & opB[W-1];
      mag_a   = a_neg ? -opA : opA;
      mag_b   = b_neg ? -opB : opB;
   end

   // Sign correction and special-case overrides, applied on the way into DONE.
   always_comb begin
      quo_fix = neg_q_reg ? -quo_reg : quo_reg;
      rem_fix = neg_r_reg ? -rem_reg[W-1:0] : rem_reg[W-1:0];
      if (zero_reg) begin
         quo_fix = '1;
         rem_fix = dividend_reg;
      end else if (ovf_reg) begin
         quo_fix = MIN_NEG;
         rem_fix = '0;
      end
      final_value = op_is_rem(op_reg) ? rem_fix : quo_fix;
   end

   // The counter sits at 32 for one extra CALC cycle after the last step,
   // which lines the done pulse up with the pipeline's 33-edge latency.
`ifdef DIV_EARLY_OUT_EN
   assign finish = (count_reg == LAST_COUNT) || zero_reg || ovf_reg;
`else
   assign finish = (count_reg == LAST_COUNT);
`endif

   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      op_next       = op_reg;
      rd_next       = rd_reg;
      quo_next      = quo_reg;
      rem_next      = rem_reg;
      divisor_next  = divisor_reg;
      dividend_next = dividend_reg;
      neg_q_next    = neg_q_reg;
      neg_r_next    = neg_r_reg;
      zero_next     = zero_reg;
      ovf_next      = ovf_reg;
      result_next   = result_reg;
      done_rd_next  = done_rd_reg;

      case (state_reg)
         S_IDLE: begin
            if (div_valid) begin
               state_next    = S_CALC;
               count_next    = '0;
               op_next       = div_op;
               rd_next       = rd;
               quo_next      = mag_a;
               rem_next      = '0;
               divisor_next  = mag_b;
               dividend_next = opA;
               neg_q_next    = a_neg ^ b_neg;
               neg_r_next    = a_neg;
               zero_next     = (opB == '0);
               ovf_next      = op_is_signed(div_op) && (opA == MIN_NEG) && (opB == '1);
            end
         end
         S_CALC: begin
            if (finish) begin
               state_next   = S_DONE;
               result_next  = final_value;
               done_rd_next = rd_reg;
            end else begin
               count_next = count_reg + 6'd1;
               if (!trial[W+1]) begin
                  rem_next = trial[W:0];
                  quo_next = {quo_reg[W-2:0], 1'b1};
               end else begin
                  rem_next = shifted;
                  quo_next = {quo_reg[W-2:0], 1'b0};
               end
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase

      // A flushed operation must leave the visible result untouched.
      if (flush) begin
         state_next   = S_IDLE;
         result_next  = result_reg;
         done_rd_next = done_rd_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         count_reg    <= '0;
         op_reg       <= '0;
         rd_reg       <= '0;
         quo_reg      <= '0;
         rem_reg      <= '0;
         divisor_reg  <= '0;
         dividend_reg <= '0;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
         zero_reg     <= 1'b0;
         ovf_reg      <= 1'b0;
         result_reg   <= '0;
         done_rd_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         op_reg       <= op_next;
         rd_reg       <= rd_next;
         quo_reg      <= quo_next;
         rem_reg      <= rem_next;
         divisor_reg  <= divisor_next;
         dividend_reg <= dividend_next;
         neg_q_reg    <= neg_q_next;
         neg_r_reg    <= neg_r_next;
         zero_reg     <= zero_next;
         ovf_reg      <= ovf_next;
         result_reg   <= result_next;
         done_rd_reg  <= done_rd_next;
      end
   end

   assign busy    = (state_reg == S_CALC);
   assign done    = (state_reg == S_DONE);
   assign result  = result_reg;
   assign done_rd = done_rd_reg;

endmodule

// File: tb/tb_exe_divider.sv
// Self-checking bench for exe_divider: vector table plus flush/reset/busy sequences,
// results checked through a scoreboard queue popped on every done pulse.
module tb_exe_divider;
   import exe_divider_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, div_valid;
   logic [1:0]  div_op;
   logic [31:0] opA, opB;
   logic [4:0]  rd;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  done_rd;

   always #5 clk = ~clk;

   exe_divider dut (
      .clk(clk), .rst(rst), .flush(flush), .div_valid(div_valid),
      .div_op(div_op), .opA(opA), .opB(opB), .rd(rd),
      .busy(busy), .done(done), .result(result), .done_rd(done_rd)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   done_cnt = 0;

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'h0 : 32'h8000_0000;
      case (op)
         2'b00:   return sa / sb;
         2'b01:   return a / b;
         2'b10:   return sa % sb;
         default: return a % b;
      endcase
   endfunction

   function automatic logic is_special(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
      return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end else begin
         $display("ok   %s = %h", name, got);
      end
   endtask

   // Scoreboard side: every done pulse must match the oldest pushed expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         n_vec++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done result=%h done_rd=%0d want=no_done", result, done_rd);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (result !== e.res || done_rd !== e.rd) begin
               n_err++;
               $display("FAIL done_result got=%h/rd%0d want=%h/rd%0d", result, done_rd, e.res, e.rd);
            end else begin
               $display("ok   done_result = %h rd%0d", result, done_rd);
            end
         end
      end
   end

   task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] exp, input bit push);
      div_op    = op;
      opA       = a;
      opB       = b;
      rd        = r;
      div_valid = 1'b1;
      if (push) sb_q.push_back('{res: exp, rd: r});
      @(posedge clk);
      #1 div_valid = 1'b0;
   endtask

   // Called 1 time unit after the accepting edge; lat = edges after it until done.
   task automatic wait_done(output logic [31:0] lat, output bit busy_ok);
      int k;
      k       = 0;
      busy_ok = 1'b1;
      lat     = 32'hFFFF_FFFF;
      while (k < 100) begin
         if (done === 1'b1) begin
            lat = k;
            return;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   initial begin
      logic [31:0] lat, exp_lat;
      bit          busy_ok;
      int          cnt_before;

      rst = 1'b1; flush = 1'b0; div_valid = 1'b1; div_op = OP_DIVU;
      opA = 32'd10; opB = 32'd2; rd = 5'd1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; div_valid = 1'b0;
      check("reset_busy",    {31'b0, busy},   32'h0);
      check("reset_done",    {31'b0, done},   32'h0);
      check("reset_result",  result,          32'h0);
      check("reset_done_rd", {27'b0, done_rd}, 32'h0);

      vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          5'd1,  32'd14});
      vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF});
      vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD});
      vecs.push_back('{OP_DIV,  32'd5,          32'd0,          5'd4,  32'hFFFF_FFFF});
      vecs.push_back('{OP_REMU, 32'd5,          32'd0,          5'd5,  32'd5});
      vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  32'h8000_0000});
      vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h0});
      vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd8,  32'hFFFF_FFFF});
      vecs.push_back('{OP_DIV,  32'd100,        32'hFFFF_FFF9,  5'd9,  32'hFFFF_FFF2});
      vecs.push_back('{OP_REM,  32'd100,        32'hFFFF_FFF9,  5'd10, 32'd2});
      vecs.push_back('{OP_REMU, 32'hFFFF_FFFF,  32'd10,         5'd11, 32'd5});
      vecs.push_back('{OP_DIV,  32'hFFFF_FFFB,  32'd0,          5'd12, 32'hFFFF_FFFF});
      vecs.push_back('{OP_REM,  32'hFFFF_FFFB,  32'd0,          5'd13, 32'hFFFF_FFFB});
      vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h0});
      for (int i = 0; i < 6; i++) begin
         logic [1:0]  rop;
         logic [31:0] ra, rb;
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         vecs.push_back('{rop, ra, rb, 5'(20 + i), ref_div(rop, ra, rb)});
      end

      foreach (vecs[i]) begin
         start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b1);
         wait_done(lat, busy_ok);
`ifdef DIV_EARLY_OUT_EN
         exp_lat = is_special(vecs[i].op, vecs[i].a, vecs[i].b) ? 32'd1 : 32'd33;
`else
         exp_lat = is_special(vecs[i].op, vecs[i].a, vecs[i].b) ? 32'd33 : 32'd33;
`endif
         check($sformatf("latency_v%0d", i), lat, exp_lat);
         check($sformatf("busy_hold_v%0d", i), {31'b0, busy_ok}, 32'h1);
         @(posedge clk);
         #1;
      end

      // Flush at CALC cycle 10, then a fresh request the very next cycle.
      start(OP_DIVU, 32'd9, 32'd3, 5'd15, 32'd3, 1'b0);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_busy", {31'b0, busy}, 32'h0);
      check("flush_done", {31'b0, done}, 32'h0);
      start(OP_DIVU, 32'd8, 32'd2, 5'd16, 32'd4, 1'b1);
      wait_done(lat, busy_ok);
      check("after_flush_latency", lat, 32'd33);
      @(posedge clk);
      #1;

      // Flush beats a simultaneous request in IDLE.
      div_op = OP_DIVU; opA = 32'd6; opB = 32'd3; rd = 5'd17;
      div_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 div_valid = 1'b0; flush = 1'b0;
      check("flush_wins_busy", {31'b0, busy}, 32'h0);

      // Reset at CALC cycle 20.
      start(OP_DIVU, 32'd1000, 32'd10, 5'd18, 32'd100, 1'b0);
      repeat (19) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("midrst_busy",    {31'b0, busy},    32'h0);
      check("midrst_result",  result,           32'h0);
      check("midrst_done_rd", {27'b0, done_rd}, 32'h0);

      // Requests during busy are dropped: exactly one done for this operation.
      cnt_before = done_cnt;
      start(OP_DIVU, 32'd50, 32'd5, 5'd19, 32'd10, 1'b1);
      repeat (3) @(posedge clk);
      #1 div_op = OP_DIVU; opA = 32'd77; opB = 32'd7; rd = 5'd9; div_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1 div_valid = 1'b0;
      wait_done(lat, busy_ok);
      check("busy_req_latency", lat, 32'd25);
      repeat (45) @(posedge clk);
      #1;
      check("single_done", 32'(done_cnt - cnt_before), 32'd1);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
